// File: rtl/jtframe_ddram_pkg.sv
// Shared types and constants for the ddram_* burst responder: FSM encoding, default latency, stall LFSR.
package jtframe_ddram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WBURST = 2'd1,
    ST_RWAIT  = 2'd2,
    ST_RDATA  = 2'd3
  } state_t;

  localparam int          DEF_LAT   = 4;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/jtframe_ddram_resp_if.sv
// MiSTer-style ddram_* Avalon burst bus; master is the DDR initiator, slave is the responder.
interface jtframe_ddram_resp_if;
  logic        ddram_busy;
  logic [7:0]  ddram_burstcnt;
  logic [28:0] ddram_addr;
  logic        ddram_rd;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;
  logic        ddram_we;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;

  modport master (
    input  ddram_busy, ddram_dout, ddram_dout_ready,
    output ddram_burstcnt, ddram_addr, ddram_rd, ddram_we, ddram_din, ddram_be
  );

  modport slave (
    output ddram_busy, ddram_dout, ddram_dout_ready,
    input  ddram_burstcnt, ddram_addr, ddram_rd, ddram_we, ddram_din, ddram_be
  );
endinterface

// File: rtl/jtframe_ddram_mem.sv
// Single-port 2^AW x 64 RAM with per-byte write enables; read data is registered (1 cycle), read-first.
module jtframe_ddram_mem #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [7:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   din_i,
  output logic [63:0]   dout_o
);
  logic [63:0] mem_q [2**AW];
  logic [63:0] dout_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we_i && be_i[i]) mem_q[addr_i][8*i +: 8] <= din_i[8*i +: 8];
    end
    dout_q <= mem_q[addr_i];
  end

  assign dout_o = dout_q;
endmodule

// File: rtl/jtframe_ddram_resp.sv
// ddram_* burst responder over BRAM: read beats start LAT cycles after acceptance; busy during reads/reset.
// Define JTFRAME_DDRAM_STALL_EN to OR LFSR-driven stalls (max 3 cycles) into busy in IDLE/WBURST.
module jtframe_ddram_resp
  import jtframe_ddram_pkg::*;
#(
  parameter int AW  = 12,
  parameter int LAT = DEF_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ddram_clk,
  jtframe_ddram_resp_if.slave ddram
);
  state_t         state_q, state_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [LAT-1:0] wait_q, wait_d;
  logic [63:0]    dout_q, dout_d;
  logic           rst_q;
  logic           stall, busy, dout_rdy, wr_acc, rd_acc;
  logic [7:0]     bcnt;
  logic [AW-1:0]  addr_lo;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [63:0]    mem_q;
  logic           unused_ok;

  assign bcnt      = (ddram.ddram_burstcnt == 8'd0) ? 8'd1 : ddram.ddram_burstcnt;
  assign addr_lo   = ddram.ddram_addr[AW-1:0];
  assign unused_ok = &{1'b0, ddram_clk, ddram.ddram_addr[28:AW]};

`ifdef JTFRAME_DDRAM_STALL_EN
  logic [15:0] lfsr_q;
  logic [1:0]  run_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
      run_q  <= 2'd0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      run_q  <= stall ? 2'(run_q + 2'd1) : 2'd0;
    end
  end

  // run_q caps consecutive stalls at three regardless of the LFSR bit pattern
  assign stall = ((state_q == ST_IDLE) || (state_q == ST_WBURST)) &&
                 (lfsr_q[2:0] == 3'b000) && (run_q != 2'd3);
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_acc)      state_d = (bcnt != 8'd1) ? ST_WBURST : ST_IDLE;
        else if (rd_acc) state_d = ST_RWAIT;
      end
      ST_WBURST: if (wr_acc && cnt_q == 8'd1) state_d = ST_IDLE;
      ST_RWAIT:  if (wait_q[LAT-1])           state_d = ST_RDATA;
      ST_RDATA:  if (cnt_q == 8'd1)           state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // busy is a pure decode of registers so the initiator never sees a loop through it
  always_comb begin
    busy     = rst_q | stall;
    dout_rdy = 1'b0;
    case (state_q)
      ST_RWAIT: busy = 1'b1;
      ST_RDATA: begin
        busy     = 1'b1;
        dout_rdy = 1'b1;
      end
      default: ;
    endcase
    wr_acc = ddram.ddram_we & ~busy & ~rst;
    rd_acc = ddram.ddram_rd & ~ddram.ddram_we & ~busy & ~rst & (state_q == ST_IDLE);
  end

  // ptr runs one word ahead of dout so the registered RAM output lands on the right beat
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q << 1;
    dout_d   = dout_q;
    mem_we   = 1'b0;
    mem_addr = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_acc) begin
          mem_we   = 1'b1;
          mem_addr = addr_lo;
          ptr_d    = addr_lo + 1'b1;
          cnt_d    = bcnt - 8'd1;
        end else if (rd_acc) begin
          ptr_d     = addr_lo;
          cnt_d     = bcnt;
          wait_d    = '0;
          wait_d[0] = 1'b1;
        end
      end
      ST_WBURST: begin
        if (wr_acc) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          cnt_d  = cnt_q - 8'd1;
        end
      end
      ST_RWAIT: begin
        if (wait_q[LAT-2] | wait_q[LAT-1]) ptr_d = ptr_q + 1'b1;
        if (wait_q[LAT-1]) dout_d = mem_q;
      end
      ST_RDATA: begin
        cnt_d = cnt_q - 8'd1;
        ptr_d = ptr_q + 1'b1;
        if (cnt_q != 8'd1) dout_d = mem_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      wait_q <= '0;
      dout_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      wait_q <= wait_d;
      dout_q <= dout_d;
    end
  end

  jtframe_ddram_mem #(.AW(AW)) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .be_i   (ddram.ddram_be),
    .addr_i (mem_addr),
    .din_i  (ddram.ddram_din),
    .dout_o (mem_q)
  );

  assign ddram.ddram_busy       = busy;
  assign ddram.ddram_dout_ready = dout_rdy;
  assign ddram.ddram_dout       = dout_q;
endmodule
